// File: rtl/req_scheduler.sv
// Elevator request scheduler: latches car/hall calls, keeps the travel direction,
// masks hall calls against that direction and clears the calls served at a stop.
module req_scheduler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       switch,
    input  logic [3:0] car_btn,
    input  logic [3:0] up_btn,
    input  logic [3:0] down_btn,
    input  logic [3:0] position,
    input  logic [2:0] state,
    input  logic       opendoor,
    input  logic       endOpen,
    output logic [3:0] eff_req,
    output logic [1:0] ud_mode,
    output logic [3:0] car_req,
    output logic [3:0] up_req,
    output logic [3:0] down_req,
    output logic       busy
);

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    localparam logic [2:0] ST_PAUSE = 3'b001;
    localparam logic [2:0] ST_MOVE  = 3'b010;

    dir_t       r_dir;
    dir_t       w_dir_nxt;
    logic [3:0] r_car;
    logic [3:0] r_up;
    logic [3:0] r_down;

    logic [3:0] w_all;
    logic [3:0] w_below;
    logic [3:0] w_above;
    logic       w_any_above;
    logic       w_any_below;
    logic       w_onehot;
    logic       w_decide;
    logic       w_clear;
    logic [3:0] w_up_eff;
    logic [3:0] w_dn_eff;
    logic [3:0] w_car_nxt;
    logic [3:0] w_up_nxt;
    logic [3:0] w_down_nxt;

    assign w_all       = r_car | r_up | r_down;
    assign w_below     = position - 4'd1;
    assign w_above     = ~((position << 1) - 4'd1);
    assign w_any_above = |(w_all & w_above);
    assign w_any_below = |(w_all & w_below);

    // A floor code that is not exactly one-hot is untrusted: no clears, no decisions.
    assign w_onehot = (position != 4'd0) && ((position & (position - 4'd1)) == 4'd0);
    assign w_decide = (state == ST_PAUSE) && !opendoor && !endOpen && w_onehot;
    assign w_clear  = endOpen && w_onehot && (state != ST_MOVE);

    // Hall calls opposing the travel direction are held back until nothing lies ahead.
    assign w_up_eff = ((r_dir != DIR_DOWN) || !w_any_below) ? r_up   : 4'd0;
    assign w_dn_eff = ((r_dir != DIR_UP)   || !w_any_above) ? r_down : 4'd0;

    always_comb begin
        w_car_nxt  = r_car;
        w_up_nxt   = r_up;
        w_down_nxt = r_down;
        if (w_clear) begin
            w_car_nxt  = r_car  & ~position;
            w_up_nxt   = r_up   & ~(position & w_up_eff);
            w_down_nxt = r_down & ~(position & w_dn_eff);
        end
        // Applied after the clear so a press on the served floor survives.
        w_car_nxt  = w_car_nxt  | car_btn;
        w_up_nxt   = w_up_nxt   | (up_btn   & 4'b0111);
        w_down_nxt = w_down_nxt | (down_btn & 4'b1110);
    end

    always_comb begin
        w_dir_nxt = r_dir;
        if (w_decide) begin
            case (r_dir)
                DIR_DOWN: begin
                    if (w_any_below)      w_dir_nxt = DIR_DOWN;
                    else if (w_any_above) w_dir_nxt = DIR_UP;
                    else                  w_dir_nxt = DIR_IDLE;
                end
                default: begin
                    if (w_any_above)      w_dir_nxt = DIR_UP;
                    else if (w_any_below) w_dir_nxt = DIR_DOWN;
                    else                  w_dir_nxt = DIR_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dir <= DIR_IDLE;
        end else if (!switch) begin
            r_dir <= DIR_IDLE;
        end else begin
            r_dir <= w_dir_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_car  <= 4'd0;
            r_up   <= 4'd0;
            r_down <= 4'd0;
        end else if (!switch) begin
            r_car  <= 4'd0;
            r_up   <= 4'd0;
            r_down <= 4'd0;
        end else begin
            r_car  <= w_car_nxt;
            r_up   <= w_up_nxt;
            r_down <= w_down_nxt;
        end
    end

    assign eff_req  = r_car | w_up_eff | w_dn_eff;
    assign ud_mode  = r_dir;
    assign car_req  = r_car;
    assign up_req   = r_up;
    assign down_req = r_down;
    assign busy     = |w_all;

endmodule
